// File: rtl/if_stage.sv
// Instruction fetch stage: assembles each 32-bit instruction from four little-endian
// byte reads and hands {pc_o, inst_o} to decode; an EX redirect flushes the fetch in flight.
module if_stage #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              if_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              dbg_state_o
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        req_cnt, rsp_cnt;
    logic [7:0]        byte0, byte1, byte2;
    logic              discard;
    logic              req_fire, rsp_fire, last_byte, handshake;

    // Handshake: decode takes {pc_o, inst_o} on a cycle with if_valid_o & id_ready_i;
    // if_valid_o never drops and the payload never changes until then, except on jump_i.
    assign req_fire  = mem_req_o & mem_gnt_i;
    assign rsp_fire  = mem_rvalid_i & ~discard & (state == FETCH) & (rsp_cnt < 3'd4);
    assign last_byte = rsp_fire & (rsp_cnt == 3'd3);
    assign handshake = if_valid_o & id_ready_i;
    assign dbg_state_o = (state == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (jump_i) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH:   if (last_byte) state_nxt = HOLD;
                HOLD:    if (handshake) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    // Requests depend only on registered state (and reset), never on same-cycle inputs.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = pc + {{(ADDR_W-3){1'b0}}, req_cnt};
        if (rst && (state == FETCH) && (req_cnt < 3'd4)) mem_req_o = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            req_cnt    <= 3'd0;
            rsp_cnt    <= 3'd0;
            byte0      <= 8'h00;
            byte1      <= 8'h00;
            byte2      <= 8'h00;
            discard    <= 1'b0;
            if_valid_o <= 1'b0;
            pc_o       <= RESET_PC;
            inst_o     <= '0;
        end else if (jump_i) begin
            // A byte granted this cycle belongs to the old stream; its return must be dropped.
            pc         <= {jump_target_i[ADDR_W-1:2], 2'b00};
            req_cnt    <= 3'd0;
            rsp_cnt    <= 3'd0;
            discard    <= req_fire;
            if_valid_o <= 1'b0;
        end else begin
            if (req_fire) req_cnt <= req_cnt + 3'd1;
            if (mem_rvalid_i && discard) discard <= 1'b0;
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + 3'd1;
                case (rsp_cnt)
                    3'd0:    byte0 <= mem_rdata_i;
                    3'd1:    byte1 <= mem_rdata_i;
                    3'd2:    byte2 <= mem_rdata_i;
                    default: ;
                endcase
            end
            if (last_byte) begin
                inst_o     <= {{(INST_W-32){1'b0}}, mem_rdata_i, byte2, byte1, byte0};
                pc_o       <= pc;
                if_valid_o <= 1'b1;
            end
            if (handshake) begin
                pc         <= pc + ADDR_W'(4);
                req_cnt    <= 3'd0;
                rsp_cnt    <= 3'd0;
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule
